pim_job_scheduler: RTL

PIM_JOB_SCHEDULER -- requirements
Module: pim_job_scheduler

---
 rtl/pim_job_scheduler_if.sv | 34 +++
 rtl/pim_job_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pim_job_scheduler_if.sv
// Signal bundle between pim_job_scheduler and its host, partitioner and PIM units.
// master = host/partitioner/unit side, slave = scheduler side.
interface pim_job_scheduler_if #(
    parameter int NUM_PIM_UNITS = 4
);
    logic                     job_start;
    logic [31:0]              matrix_size;
    logic                     err_clear;
    logic                     part_start;
    logic                     partition_done;
    logic [NUM_PIM_UNITS-1:0] valid_in;
    logic [NUM_PIM_UNITS-1:0] pim_start;
    logic [NUM_PIM_UNITS-1:0] pim_done;
    logic [NUM_PIM_UNITS-1:0] active_mask;
    logic                     busy;
    logic                     job_done;
    logic                     job_error;
    logic [1:0]               err_code;
    logic [31:0]              job_cycles;

    modport master (
        output job_start, matrix_size, err_clear,
        output partition_done, valid_in, pim_done,
        input  part_start, pim_start, active_mask, busy,
        input  job_done, job_error, err_code, job_cycles
    );

    modport slave (
        input  job_start, matrix_size, err_clear,
        input  partition_done, valid_in, pim_done,
        output part_start, pim_start, active_mask, busy,
        output job_done, job_error, err_code, job_cycles
    );
endinterface

// File: rtl/pim_job_scheduler.sv
// Sequences one matrix job: partition, dispatch to PIM units in index
// order, collect completions, report done/timeout/error with cycle count.
module pim_job_scheduler #(
    parameter int NUM_PIM_UNITS   = 4,
    parameter int MAX_MATRIX_SIZE = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic                clk,
    input logic                rst_n,
    pim_job_scheduler_if.slave bus
);
    localparam int PW = (NUM_PIM_UNITS > 1) ? $clog2(NUM_PIM_UNITS) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_PIM_UNITS - 1);
    localparam logic [31:0] TLAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAXSZ = 32'(MAX_MATRIX_SIZE);

    typedef logic [NUM_PIM_UNITS-1:0] mask_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PART,
        S_DISPATCH,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic        part_start_q, part_start_d;
    mask_t       pim_start_q, pim_start_d;
    mask_t       active_q, active_d;
    mask_t       done_mask_q, done_mask_d;
    mask_t       started_q, started_d;
    logic        busy_q, busy_d;
    logic        job_done_q, job_done_d;
    logic        job_error_q, job_error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] job_cycles_q, job_cycles_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] jcnt_q, jcnt_d;

    logic [PW-1:0] ptr_nxt;
    mask_t         hit;
    mask_t         done_nxt;
    logic          size_ok;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        part_start_d = 1'b0;
        pim_start_d  = '0;
        active_d     = active_q;
        done_mask_d  = done_mask_q;
        started_d    = started_q | pim_start_q;
        job_done_d   = 1'b0;
        job_error_d  = job_error_q;
        err_code_d   = err_code_q;
        job_cycles_d = job_cycles_q;
        ptr_d        = ptr_q;
        tcnt_d       = tcnt_q;
        jcnt_d       = (jcnt_q == '1) ? jcnt_q : jcnt_q + 32'd1;
        ptr_nxt      = ptr_q + PW'(1);
        hit          = bus.pim_done & active_q & started_q;
        done_nxt     = done_mask_q | hit;
        size_ok      = (bus.matrix_size != 32'd0) &&
                       (bus.matrix_size <= MAXSZ);

        unique case (state_q)
            S_IDLE: begin
                if (bus.job_start) begin
                    if (size_ok) begin
                        state_d      = S_PART;
                        part_start_d = 1'b1;
                        active_d     = '0;
                        done_mask_d  = '0;
                        started_d    = '0;
                        err_code_d   = 2'd0;
                        jcnt_d       = 32'd1;
                    end else begin
                        state_d     = S_ERROR;
                        job_error_d = 1'b1;
                        err_code_d  = 2'd1;
                    end
                end
            end
            S_PART: begin
                if (bus.partition_done) begin
                    active_d = bus.valid_in;
                    if (bus.valid_in == '0) begin
                        state_d     = S_ERROR;
                        job_error_d = 1'b1;
                        err_code_d  = 2'd2;
                    end else begin
                        state_d     = S_DISPATCH;
                        ptr_d       = '0;
                        tcnt_d      = 32'd0;
                        pim_start_d = bus.valid_in & mask_t'(1);
                    end
                end
            end
            S_DISPATCH: begin
                done_mask_d = done_nxt;
                tcnt_d      = tcnt_q + 32'd1;
                if (tcnt_q == TLAST) begin
                    state_d     = S_ERROR;
                    job_error_d = 1'b1;
                    err_code_d  = 2'd3;
                end else if (ptr_q == LAST_PTR) begin
                    state_d = S_WAIT;
                end else begin
                    ptr_d       = ptr_nxt;
                    pim_start_d = active_q & (mask_t'(1) << ptr_nxt);
                end
            end
            S_WAIT: begin
                done_mask_d = done_nxt;
                tcnt_d      = tcnt_q + 32'd1;
                if (done_nxt == active_q) begin
                    state_d      = S_DONE;
                    job_done_d   = 1'b1;
                    job_cycles_d = jcnt_d;
                end else if (tcnt_q == TLAST) begin
                    state_d     = S_ERROR;
                    job_error_d = 1'b1;
                    err_code_d  = 2'd3;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (bus.err_clear) begin
                    state_d     = S_IDLE;
                    job_error_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            part_start_q <= 1'b0;
            pim_start_q  <= '0;
            active_q     <= '0;
            done_mask_q  <= '0;
            started_q    <= '0;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            job_error_q  <= 1'b0;
            err_code_q   <= 2'd0;
            job_cycles_q <= 32'd0;
            ptr_q        <= '0;
            tcnt_q       <= 32'd0;
            jcnt_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            part_start_q <= part_start_d;
            pim_start_q  <= pim_start_d;
            active_q     <= active_d;
            done_mask_q  <= done_mask_d;
            started_q    <= started_d;
            busy_q       <= busy_d;
            job_done_q   <= job_done_d;
            job_error_q  <= job_error_d;
            err_code_q   <= err_code_d;
            job_cycles_q <= job_cycles_d;
            ptr_q        <= ptr_d;
            tcnt_q       <= tcnt_d;
            jcnt_q       <= jcnt_d;
        end
    end

    assign bus.part_start  = part_start_q;
    assign bus.pim_start   = pim_start_q;
    assign bus.active_mask = active_q;
    assign bus.busy        = busy_q;
    assign bus.job_done    = job_done_q;
    assign bus.job_error   = job_error_q;
    assign bus.err_code    = err_code_q;
    assign bus.job_cycles  = job_cycles_q;
endmodule
